// File: rtl/hack_pkg.sv
// Shared definitions for the Hack control unit: sequencer states,
// instruction word width and the bit positions of every instruction field.
package hack_pkg;

  localparam int INSTR_W    = 16;

  localparam int IDX_CTYPE  = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int IDX_A      = 12;  // y operand select: 0 = A, 1 = M
  localparam int IDX_ALU_HI = 11;  // zx nx zy ny f no
  localparam int IDX_ALU_LO = 6;
  localparam int IDX_DA     = 5;
  localparam int IDX_DD     = 4;
  localparam int IDX_DM     = 3;
  localparam int IDX_J_HI   = 2;   // j1 j2 j3
  localparam int IDX_J_LO   = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_COMMIT
  } state_t;

  function automatic logic is_c_instr(input logic [INSTR_W-1:0] ir);
    return ir[IDX_CTYPE];
  endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// Jump condition evaluator.
// Ports:
//   i_j    [2:0]  jump bits j1 j2 j3 (lt, eq, gt)
//   i_zr          result was zero
//   i_ng          result was negative
//   o_jump        take the jump
module hack_jump_cond (
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jump
);

  assign o_jump = (i_j[2] & i_ng) | (i_j[1] & i_zr) | (i_j[0] & ~i_ng & ~i_zr);

endmodule

// File: rtl/hack_alu_sequencer.sv
// Multi-cycle Hack control unit. Fetches, decodes and sequences each
// instruction, drives an external ALU and owns the A, D and PC registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | imem_req high at PC until imem_ack; latch IR
// S_DECODE | A-instr: load A, PC+1; C-instr: choose M read or execute
// S_MEM_RD | dmem_rd at A until dmem_ack; latch M
// S_EXEC   | capture ALU result and flags
// S_MEM_WR | dmem_wr of result at A until dmem_ack
// S_COMMIT | update PC (jump or +1), A and D together
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imem_req/addr/ack/data            instruction fetch interface
//   dmem_rd/wr/addr/wdata/ack/rdata   data memory interface
//   alu_x, alu_y, alu_zx..alu_no      ALU operands and control bits
//   alu_out, alu_zr, alu_ng           ALU result and flags
//   pc                                current PC (debug)
module hack_alu_sequencer
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dmem_rd,
  output logic               dmem_wr,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [INSTR_W-1:0] dmem_wdata,
  input  logic               dmem_ack,
  input  logic [INSTR_W-1:0] dmem_rdata,
  output logic [INSTR_W-1:0] alu_x,
  output logic [INSTR_W-1:0] alu_y,
  output logic               alu_zx,
  output logic               alu_nx,
  output logic               alu_zy,
  output logic               alu_ny,
  output logic               alu_f,
  output logic               alu_no,
  input  logic [INSTR_W-1:0] alu_out,
  input  logic               alu_zr,
  input  logic               alu_ng,
  output logic [ADDR_W-1:0]  pc
);

  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic [INSTR_W-1:0]   r_a, r_d, r_ir, r_m, r_res;
  logic                 r_zr, r_ng;
  logic                 w_jump;

  assign w_pc_inc = r_pc + ADDR_W'(1);

  hack_jump_cond u_jump_cond (
    .i_j    (r_ir[IDX_J_HI:IDX_J_LO]),
    .i_zr   (r_zr),
    .i_ng   (r_ng),
    .o_jump (w_jump)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Requests are gated by rst_n so an in-flight access drops the moment
  // reset asserts, not at the next clock.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_rd  = 1'b0;
    dmem_wr  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        imem_req = rst_n;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!is_c_instr(r_ir))  w_next = S_FETCH;
        else if (r_ir[IDX_A])   w_next = S_MEM_RD;
        else                    w_next = S_EXEC;
      end
      S_MEM_RD: begin
        dmem_rd = rst_n;
        if (dmem_ack) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = r_ir[IDX_DM] ? S_MEM_WR : S_COMMIT;
      end
      S_MEM_WR: begin
        dmem_wr = rst_n;
        if (dmem_ack) w_next = S_COMMIT;
      end
      S_COMMIT: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_a   <= '0;
      r_d   <= '0;
      r_ir  <= '0;
      r_m   <= '0;
      r_res <= '0;
      r_zr  <= 1'b0;
      r_ng  <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: if (imem_ack) r_ir <= imem_data;
        S_DECODE: begin
          if (!is_c_instr(r_ir)) begin
            r_a  <= {1'b0, r_ir[IDX_CTYPE-1:0]};
            r_pc <= w_pc_inc;
          end
        end
        S_MEM_RD: if (dmem_ack) r_m <= dmem_rdata;
        S_EXEC: begin
          r_res <= alu_out;
          r_zr  <= alu_zr;
          r_ng  <= alu_ng;
        end
        S_COMMIT: begin
          // r_a here is still the pre-instruction A, so the jump target
          // ignores this instruction's own A write.
          r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
          if (r_ir[IDX_DA]) r_a <= r_res;
          if (r_ir[IDX_DD]) r_d <= r_res;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_addr  = r_a[ADDR_W-1:0];
  assign dmem_wdata = r_res;
  assign alu_x      = r_d;
  assign alu_y      = r_ir[IDX_A] ? r_m : r_a;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = r_ir[IDX_ALU_HI:IDX_ALU_LO];

endmodule

// File: tb/tb_hack_alu_sequencer.sv
module tb_hack_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [14:0] imem_addr;
  logic [15:0] imem_data;
  logic        dmem_rd, dmem_wr, dmem_ack;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [14:0] pc;

  int checks = 0;
  int errors = 0;

  // ISA-level reference state
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [15:0] m_mem   [int];
  logic [15:0] dev_mem [int];

  always #5 clk = ~clk;

  hack_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc)
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0000 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return o;
  endfunction

  // External ALU model sitting beside the sequencer
  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  function automatic logic [15:0] m_rd(input int addr);
    return m_mem.exists(addr) ? m_mem[addr] : 16'h0000;
  endfunction

  function automatic logic [15:0] dev_rd(input int addr);
    return dev_mem.exists(addr) ? dev_mem[addr] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a  = 16'h0000;
    m_d  = 16'h0000;
    m_pc = 15'h0000;
  endtask

  // Entered at a negedge with the DUT waiting in fetch; returns at the
  // negedge where the next fetch request is visible.
  task automatic exec_instr(input logic [15:0] ins, input int iw, input int dw,
                            input bit rst_in_wr, output bit aborted);
    logic [15:0] y, r, n_a, n_d;
    logic [14:0] n_pc;
    logic        jmp;
    int          cyc, exp_cyc, waited, n_rd, n_wr, limit;
    bit          done;
    #1;
    aborted = 0;
    chk("fetch_req",  imem_req,  1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("pc_out",     pc,        m_pc);
    chk("d_reg",      alu_x,     m_d);
    chk("a_addr",     dmem_addr, m_a[14:0]);
    chk("no_dmem",    dmem_rd | dmem_wr, 0);

    // Reference result from ISA rules
    r = 16'h0000;
    n_a = m_a; n_d = m_d;
    if (!ins[15]) begin
      n_a     = {1'b0, ins[14:0]};
      n_pc    = m_pc + 15'd1;
      exp_cyc = 2;
    end else begin
      y   = ins[12] ? m_rd(int'(m_a[14:0])) : m_a;
      r   = hack_alu(m_d, y, ins[11:6]);
      jmp = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'h0000) || (ins[0] && $signed(r) > 0);
      n_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
      if (ins[5]) n_a = r;
      if (ins[4]) n_d = r;
      exp_cyc = 4 + int'(ins[12]) + int'(ins[3]) + dw * (int'(ins[12]) + int'(ins[3]));
    end

    cyc = 0;
    for (int k = 0; k < iw; k++) begin
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      @(negedge clk); cyc++;
      chk("fetch_hold_req",  imem_req,  1);
      chk("fetch_hold_addr", imem_addr, m_pc);
    end
    imem_ack  = 1'b1;
    imem_data = ins;
    @(negedge clk); cyc++;
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    chk("req_drop", imem_req, 0);
    if (ins[15]) begin
      chk("alu_ctl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, ins[11:6]);
      if (!ins[12]) chk("alu_y_a", alu_y, m_a);
    end

    waited = 0; n_rd = 0; n_wr = 0; done = 0;
    limit  = iw + 4 * dw + 20;
    while (!done && cyc < limit) begin
      chk("rd_wr_excl", dmem_rd & dmem_wr, 0);
      if (imem_req) begin
        done = 1;
      end else begin
        dmem_ack = 1'b0;
        if (dmem_wr && rst_in_wr) begin
          rst_n = 1'b0;
          #1;
          chk("rst_wr_drop",  dmem_wr,  0);
          chk("rst_req_low",  imem_req, 0);
          chk("rst_pc",       pc,       0);
          @(negedge clk);
          rst_n = 1'b1;
          model_reset();
          aborted = 1;
          return;
        end
        if (dmem_rd || dmem_wr) begin
          if (waited >= dw) begin
            dmem_ack = 1'b1;
            waited   = 0;
            if (dmem_rd) begin
              n_rd++;
              chk("rd_addr", dmem_addr, m_a[14:0]);
              dmem_rdata = dev_rd(int'(dmem_addr));
            end else begin
              n_wr++;
              chk("wr_addr",  dmem_addr,  m_a[14:0]);
              chk("wr_data",  dmem_wdata, r);
              dev_mem[int'(dmem_addr)] = dmem_wdata;
            end
          end else begin
            waited++;
          end
        end
        @(negedge clk); cyc++;
      end
    end
    dmem_ack = 1'b0;
    chk("timeout",   done, 1);
    chk("latency",   cyc, iw + exp_cyc);
    chk("rd_count",  n_rd, int'(ins[15] & ins[12]));
    chk("wr_count",  n_wr, int'(ins[15] & ins[3]));

    if (ins[15] && ins[3]) m_mem[int'(m_a[14:0])] = r;
    m_a  = n_a;
    m_d  = n_d;
    m_pc = n_pc;
  endtask

  bit          ab;
  logic [15:0] rins;
  logic [15:0] dset [3];

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    dmem_ack = 1'b0; dmem_rdata = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req,   0);
    chk("rst_dmem_rd",  dmem_rd,    0);
    chk("rst_dmem_wr",  dmem_wr,    0);
    chk("rst_wdata",    dmem_wdata, 0);
    chk("rst_pc",       pc,         0);
    chk("rst_d",        alu_x,      0);
    chk("rst_y",        alu_y,      0);
    rst_n = 1'b1;

    // First fetch and A-instruction
    exec_instr(16'h0005, 0, 0, 0, ab);
    chk("a_is_5", dmem_addr, 15'd5);
    chk("pc_is_1", pc, 15'd1);

    // D=A then D=D+A with A=7
    exec_instr(16'h0007, 0, 0, 0, ab);
    exec_instr(16'hEC10, 0, 0, 0, ab);
    exec_instr(16'hE090, 1, 0, 0, ab);
    chk("d_is_14", alu_x, 16'd14);

    // M=M+1 at address 100
    m_mem[100] = 16'h1234; dev_mem[100] = 16'h1234;
    exec_instr(16'h0064, 0, 0, 0, ab);
    exec_instr(16'hFDC8, 0, 1, 0, ab);
    chk("mem100", dev_rd(100), 16'h1235);

    // AM=D;JEQ jumps to the old A
    exec_instr(16'h0014, 0, 0, 0, ab);
    exec_instr(16'hEA90, 0, 0, 0, ab);
    dev_mem[20] = 16'hBEEF; m_mem[20] = 16'hBEEF;
    exec_instr(16'hE32A, 0, 0, 0, ab);
    chk("jeq_pc", pc, 15'd20);
    chk("jeq_a",  dmem_addr, 15'd0);
    chk("mem20",  dev_rd(20), 16'h0000);

    // Fetch wait states, then reset during a write
    exec_instr(16'h0032, 3, 0, 0, ab);
    exec_instr(16'hE308, 0, 5, 1, ab);
    chk("abort_seen", ab, 1);
    exec_instr(16'h0009, 0, 0, 0, ab);

    // PC wrap: jump to 0x7FFF then execute an A-instruction there
    exec_instr(16'h7FFF, 0, 0, 0, ab);
    exec_instr(16'hEA87, 0, 0, 0, ab);
    chk("at_top", pc, 15'h7FFF);
    exec_instr(16'h0001, 0, 0, 0, ab);
    chk("wrapped", pc, 15'h0000);

    // Jump sweep with D = -1, 0, 1
    dset[0] = 16'hEE90; dset[1] = 16'hEA90; dset[2] = 16'hEFD0;
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 8; j++) begin
        exec_instr(16'h0123, 0, 0, 0, ab);
        exec_instr(dset[v], 0, 0, 0, ab);
        exec_instr(16'hE300 | 16'(j), 0, 0, 0, ab);
      end
    end

    // Random instruction stream with random wait states
    for (int n = 0; n < 150; n++) begin
      rins = 16'($urandom);
      exec_instr(rins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_alu_sequencer.md
Name: hack_alu_sequencer

Overview:
- Multi-cycle Hack control unit and the driving end of the ALU interface: fetches 16-bit Hack instructions, decodes them into the six ALU control bits and the x/y operands, and consumes the ALU result, zr and ng.
- Owns the A, D and PC registers, performs data-memory read/write for the M operand, and evaluates jumps.
- The ALU is instantiated alongside this block, not inside it.

Parameters:
- ADDR_W, 15, width of PC, A-address and memory address buses.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_ack  in  1  fetch complete, imem_data valid this cycle
- imem_data  in  16  instruction word
- dmem_rd  out  1  data read request
- dmem_wr  out  1  data write request
- dmem_addr  out  ADDR_W  data address (= A[ADDR_W-1:0])
- dmem_wdata  out  16  write data
- dmem_ack  in  1  data access complete; rdata valid this cycle on reads
- dmem_rdata  in  16  read data
- alu_x  out  16  ALU x operand (= D)
- alu_y  out  16  ALU y operand (A or latched M)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_out  in  16  ALU result
- alu_zr  in  1  result == 0
- alu_ng  in  1  result < 0
- pc  out  ADDR_W  current PC (debug)

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low. On assertion: PC=RESET_PC, A=0, D=0, IR=0, result regs=0, state=FETCH, imem_req/dmem_rd/dmem_wr=0, dmem_wdata=0. Reset mid-transaction abandons the request immediately; memory must tolerate a dropped request.
- Encoding: bit15=0 A-instr (value = bits[14:0]). Bit15=1 C-instr: [12]=a, [11:6]=zx nx zy ny f no, [5]=dA, [4]=dD, [3]=dM, [2:0]=j1 j2 j3; bits[14:13] ignored.
- States: FETCH, DECODE, MEM_RD, EXEC, MEM_WR, COMMIT.
- FETCH: imem_req=1, imem_addr=PC, held stable until imem_ack sampled 1 (ack on the first request cycle allowed). On ack: IR<=imem_data, go to DECODE; imem_req=0 from the next cycle.
- DECODE: A-instr: A<={0,IR[14:0]}, PC<=PC+1, go to FETCH. C-instr: a=1 goes to MEM_RD, else EXEC.
- MEM_RD: dmem_rd=1, dmem_addr=A until dmem_ack. On ack: Mreg<=dmem_rdata, go to EXEC.
- ALU controls = IR[11:6]; alu_x=D; alu_y = a ? Mreg : A. Driven continuously from IR.
- EXEC (1 cycle): RES<=alu_out, ZR<=alu_zr, NG<=alu_ng. dM=1 goes to MEM_WR, else COMMIT.
- MEM_WR: dmem_wr=1, dmem_addr=A (pre-instruction value), dmem_wdata=RES, held until dmem_ack, then COMMIT. dmem_rd and dmem_wr are never both 1.
- COMMIT (1 cycle), all updates on the same edge:
  - jump = (j1&NG)|(j2&ZR)|(j3&~NG&~ZR).
  - PC <= jump ? A_old[ADDR_W-1:0] : PC+1.
  - A<=RES if dA; D<=RES if dD.
  - Go to FETCH.
- Jump target is always the A value before this instruction's write, including when dA=1.
- PC+1 wraps modulo 2^ADDR_W (0x7FFF to 0x0000).
- Latency with zero-wait memory (ack in first request cycle):
  - A-instr: 2 cycles.
  - C-instr: 4 cycles; +1 for a=1; +1 for dM=1.

Decomposition:
- Shared package hack_pkg:
  - state enum.
  - Instruction field bit-position constants: IDX_CTYPE=15, IDX_A=12, ALU control slice 11:6, dest 5:3, jump 2:0.
  - Instruction width 16.
- Sub-module hack_jump_cond: combinational (j[2:0], zr, ng) -> jump. Reused by the verification model.

Test Plan:
- Reset then fetch: release rst_n with imem_ack tied 1 -> first imem_addr=0; word 0x0005 -> A=5, PC=1 after 2 cycles.
- D=A arithmetic: program @7, D=A (0xEC10), D=D+A (0xE090) -> alu controls 000010 on the third instruction; D=14 after COMMIT.
- M read/write: A=100, memory[100]=0x1234; M=M+1 (0xFDC8) -> one dmem_rd at addr 100, then dmem_wr at addr 100 with wdata 0x1235, rd/wr never overlapping.
- Jump using old A: A=20, D=0; AM=D;JEQ (0xE32A) -> RES=0, ZR=1, A<=0, PC<=20 (not 0), memory[20] written with 0.
- Wait states and reset mid-transaction: hold imem_ack low 3 cycles -> imem_req and imem_addr stable throughout. Assert rst_n low during MEM_WR -> dmem_wr drops the same cycle; PC=0 and state=FETCH after release.
- Wrap and jump conditions: PC=0x7FFF executing an A-instr -> PC=0x0000. Sweep j=000..111 with RES in {-1, 0, 1} -> jump matches hack_jump_cond (e.g. JLE jumps for -1 and 0, not for 1).
